// File: rtl/mips_mem_pkg.sv
// Shared types for the load/store unit: opcode encodings, FSM states, request bundle.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package mips_mem_pkg;

  localparam int unsigned XLEN = 32;

  // Opcode encodings as presented on req_op by the pipeline.
  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_SW  = 3'b011,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101,
    OP_SB  = 3'b110,
    OP_SH  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Latched request: everything the FSM needs after the accept edge.
  typedef struct packed {
    op_e             op;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

  function automatic logic is_store(input op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Only LB/LH sign-extend; LBU/LHU zero-extend, LW is passed through.
  function automatic logic is_signed(input op_e op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic logic is_byte_op(input op_e op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
  endfunction

  // Words need a 4-byte aligned address, halfwords a 2-byte one; bytes never fault.
  function automatic logic is_misaligned(input op_e op, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (op)
      OP_LW, OP_SW:         mis = (off != 2'b00);
      OP_LH, OP_LHU, OP_SH: mis = off[0];
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract/extend for loads and lane merge for sub-word stores (little-endian).
// Latency: purely combinational.
// Backpressure: none; the owning FSM decides when the results are used.
module lsu_align
  import mips_mem_pkg::*;
(
  input  op_e         op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] old_word_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select the addressed byte/halfword of the fetched word.
  assign byte_lane = rd_word_i[{off_i, 3'b000} +: 8];
  assign half_lane = rd_word_i[{off_i[1], 4'b0000} +: 16];

  // Extend the selected lane to a full word according to the load flavour.
  always_comb begin
    load_o = rd_word_i;
    case (op_i)
      OP_LB, OP_LBU: load_o = is_signed(op_i) ? {{24{byte_lane[7]}}, byte_lane}
                                              : {24'h000000, byte_lane};
      OP_LH, OP_LHU: load_o = is_signed(op_i) ? {{16{half_lane[15]}}, half_lane}
                                              : {16'h0000, half_lane};
      default:       load_o = rd_word_i;
    endcase
  end

  // Overwrite only the addressed lane of the old word; other lanes keep their contents.
  always_comb begin
    merge_o = old_word_i;
    if (is_byte_op(op_i)) begin
      merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
    end else begin
      merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the pipeline and a word-wide memory.
// Latency from accept: misaligned 1 cycle, loads/SW 2 cycles, SB/SH 3 cycles (read-modify-write).
// Backpressure: req_ready only in IDLE; response is held stable in RESP until resp_ready.
module load_store_unit
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_access_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_write_en,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] old_q, old_d;

  logic [31:0] load_word;
  logic [31:0] merge_word;
  op_e         in_op;

  assign in_op = op_e'(req_op);

  lsu_align u_align (
    .op_i       (req_q.op),
    .off_i      (req_q.addr[1:0]),
    .rd_word_i  (mem_read_data),
    .old_word_i (old_q),
    .wdata_i    (req_q.wdata[15:0]),
    .load_o     (load_word),
    .merge_o    (merge_word)
  );

  // State and datapath registers; reset wins over every handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      old_q   <= old_d;
    end
  end

  // Next-state and output decode; all memory/response outputs are zero unless a state drives them.
  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    old_d           = old_q;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_rdata      = '0;
    resp_err        = 1'b0;
    mem_read        = 1'b0;
    mem_write_en    = 1'b0;
    mem_access_addr = '0;
    mem_write_data  = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d.op    = in_op;
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          rdata_d     = '0;
          if (is_misaligned(in_op, req_addr[1:0])) begin
            // Faulting request skips memory entirely and answers next cycle.
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        mem_access_addr = {req_q.addr[31:2], 2'b00};
        if (req_q.op == OP_SW) begin
          mem_write_en   = 1'b1;
          mem_write_data = req_q.wdata;
          rdata_d        = '0;
          state_d        = ST_RESP;
        end else if (is_store(req_q.op)) begin
          // Sub-word store: fetch the old word so untouched lanes survive the write.
          mem_read = 1'b1;
          old_d    = mem_read_data;
          state_d  = ST_MERGE;
        end else begin
          mem_read = 1'b1;
          rdata_d  = load_word;
          state_d  = ST_RESP;
        end
      end

      ST_MERGE: begin
        mem_access_addr = {req_q.addr[31:2], 2'b00};
        mem_write_en    = 1'b1;
        mem_write_data  = merge_word;
        rdata_d         = '0;
        state_d         = ST_RESP;
      end

      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An abort must never leave a half-merged word in memory.
    if (rst) begin
      mem_write_en = 1'b0;
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be none; address and data widths SHALL be fixed at 32 bits.
REQ-002 Clocking SHALL be one clock, clk, rising edge; reset SHALL be synchronous and active-high, port rst.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  pipeline presents a memory operation.
REQ-006 req_ready  output  1  unit can accept a request (high only in IDLE).
REQ-007 req_op  input  3  LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=110, SH=111, SW=011.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  pipeline accepts the response.
REQ-012 resp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-013 resp_err  output  1  misaligned access; no memory access was made.
REQ-014 mem_access_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-015 mem_write_data  output  32  full word to write.
REQ-016 mem_write_en  output  1  one-cycle write strobe.
REQ-017 mem_read  output  1  read enable; memory returns data combinationally in the same cycle.
REQ-018 mem_read_data  input  32  word from memory.

Function
REQ-019 The FSM SHALL have the states IDLE, ACCESS, MERGE, RESP.
REQ-020 In IDLE, req_valid&&req_ready SHALL latch op, addr and wdata, then go to RESP if misaligned, else go to ACCESS.
REQ-021 Misaligned SHALL mean: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]=1; byte ops are never misaligned.
REQ-022 In ACCESS, LW/LH/LHU/LB/LBU SHALL assert mem_read, capture mem_read_data at the clock edge, then go to RESP.
REQ-023 In ACCESS, SW SHALL assert mem_write_en with mem_write_data=wdata, then go to RESP.
REQ-024 In ACCESS, SB/SH SHALL assert mem_read and capture the old word, then go to MERGE.
REQ-025 In MERGE, the unit SHALL replace only the addressed byte/halfword lane with wdata[7:0]/wdata[15:0], assert mem_write_en for exactly one cycle, then go to RESP.
REQ-026 Lanes SHALL be little-endian: byte k = bits [8k+7:8k] for addr[1:0]=k; halfword at bits [16*addr[1]+15:16*addr[1]].
REQ-027 LB/LH SHALL sign-extend the lane to 32 bits; LBU/LHU SHALL zero-extend it; LW SHALL return the word unchanged.
REQ-028 In RESP, resp_valid SHALL be held with stable rdata/err until resp_ready=1, then go to IDLE.
REQ-029 Latency from the accept edge T SHALL be: misaligned resp_valid at T+1; LW/SW/loads at T+2; SB/SH at T+3, with resp_ready tied high.
REQ-030 mem_read and mem_write_en SHALL never be high in the same cycle, and both SHALL be 0 outside ACCESS/MERGE.
REQ-031 mem_access_addr SHALL be driven from the latched address in ACCESS/MERGE and SHALL be 0 otherwise.
REQ-032 Requests arriving while req_ready=0 SHALL be ignored, and the pipeline SHALL hold them.
REQ-033 Back-to-back requests SHALL be allowed: the cycle after RESP completes, IDLE accepts again.

Reset
REQ-034 rst=1 SHALL force IDLE on the next edge: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write_en=0, mem_access_addr=0, mem_write_data=0.
REQ-035 Reset asserted in MERGE SHALL suppress the write in every cycle where rst=1, and no response SHALL be issued for the aborted request.
REQ-036 Reset SHALL take priority over all handshakes in the same cycle.

Structure
REQ-037 Package mips_mem_pkg SHALL hold the req_op encodings, the FSM state enum, and an is_store/is_signed helper mapping.
REQ-038 Sub-module lsu_align SHALL contain the combinational lane extract/extend and lane merge; the FSM and registers SHALL stay in load_store_unit.

Verification
REQ-039 Word round-trip: with the memory preset so word 0x40 = 0x00000000, SW addr=0x40 wdata=0xDEADBEEF, then LW 0x40 -> rdata=0xDEADBEEF, err=0, resp at T+2.
REQ-040 Byte merge: with the word at 0x40 = 0xDEADBEEF, SB addr=0x41 wdata=0x12, then LW 0x40 -> 0xDEAD12EF; exactly one mem_write_en pulse, resp at T+3.
REQ-041 Extension: with the word at 0x40 = 0x8000FF80, LB 0x40 -> 0xFFFFFF80; LBU 0x40 -> 0x00000080; LH 0x42 -> 0xFFFF8000; LHU 0x42 -> 0x00008000.
REQ-042 Misaligned: LW 0x42 and SH 0x43 -> err=1, rdata=0, resp at T+1, with no mem_read or mem_write_en asserted.
REQ-043 Backpressure: hold resp_ready=0 for 5 cycles during RESP -> resp_valid and rdata stable, req_ready=0, and req_valid ignored.
REQ-044 Reset mid-op: assert rst in the cycle the FSM enters MERGE for an SB -> no write, word unchanged, next cycle IDLE with all outputs at reset values.
